// File: rtl/ble_framer_pkg.sv
// Shared definitions for the BLE packet framer: state encoding, CRC24 and
// whitening polynomials, and on-air field lengths.
package ble_framer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFETCH,
        S_PRE,
        S_AA,
        S_PDU,
        S_CRC,
        S_DONE
    } state_t;

    // x^24+x^10+x^9+x^6+x^4+x^3+x+1, Galois form with the x^24 term implied.
    localparam logic [23:0] CRC_POLY = 24'h00065B;

    // x^7+x^4+1: the bit leaving position 6 re-enters at positions 0 and 4.
    localparam logic [6:0] WH_TAPS = 7'b001_0001;

    localparam int PRE_LEN = 8;
    localparam int AA_LEN  = 32;
    localparam int CRC_LEN = 24;

    // The preamble alternates so that its last bit differs from the first
    // access-address bit.
    function automatic logic [7:0] preamble_for(input logic [31:0] access_addr);
        return access_addr[0] ? 8'h55 : 8'hAA;
    endfunction

endpackage

// File: rtl/ble_crc_whiten.sv
// Bit-serial CRC24 generator and 7-bit whitening LFSR. Shifting the CRC with
// bit_in tied to crc_msb cancels the feedback and shifts the result out.
module ble_crc_whiten
    import ble_framer_pkg::*;
#(
    parameter logic [23:0] CRC_INIT = 24'h555555
) (
    input  logic       pll_clko,
    input  logic       ble_rst,
    input  logic       load,
    input  logic [6:0] seed,
    input  logic       shift_crc,
    input  logic       shift_wh,
    input  logic       bit_in,
    output logic       crc_msb,
    output logic       wh_bit
);

    logic [23:0] r_crc;
    logic [6:0]  r_wh;
    logic        w_crc_fb;

    assign w_crc_fb = r_crc[23] ^ bit_in;
    assign crc_msb  = r_crc[23];
    assign wh_bit   = r_wh[6];

    // NOTE: registers update with <= so every flop samples pre-edge values.
    always_ff @(posedge pll_clko or negedge ble_rst) begin
        if (!ble_rst) begin
            r_crc <= CRC_INIT;
            r_wh  <= 7'h40;
        end else if (load) begin
            r_crc <= CRC_INIT;
            r_wh  <= seed;
        end else begin
            if (shift_crc) begin
                r_crc <= {r_crc[22:0], 1'b0} ^ (w_crc_fb ? CRC_POLY : 24'h0);
            end
            if (shift_wh) begin
                r_wh <= {r_wh[5:0], 1'b0} ^ (r_wh[6] ? WH_TAPS : 7'h0);
            end
        end
    end

endmodule

// File: rtl/ble_pkt_framer.sv
// BLE on-air bit source for the FSK modulator: preamble, access address,
// PDU bytes from packet memory and CRC24, with optional whitening.
module ble_pkt_framer
    import ble_framer_pkg::*;
#(
    parameter logic [31:0] ACCESS_ADDR = 32'h8E89BED6,
    parameter logic [23:0] CRC_INIT    = 24'h555555,
    parameter int          MEM_WAIT    = 8,
    parameter int          AW          = 8
) (
    input  logic          pll_clko,
    input  logic          ble_rst,
    input  logic          ready,
    input  logic [7:0]    pkt_size,
    input  logic [5:0]    chan_idx,
    input  logic          whiten_en,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_q,
    input  logic          sym_done,
    output logic          start,
    output logic          sym_val,
    output logic          busy,
    output logic          done
);

    localparam int         WW       = $clog2(MEM_WAIT + 1);
    localparam logic [7:0] PREAMBLE = preamble_for(ACCESS_ADDR);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_sd_meta, r_sd_sync, r_sd_hist, r_ready_d;
    logic [7:0]    r_pkt_size, r_byte_buf, r_shadow, r_byte_cnt;
    logic [2:0]    r_bit_cnt;
    logic [4:0]    r_field_cnt;
    logic          r_whiten_en, r_fetch_busy;
    logic [WW-1:0] r_wait_cnt;
    logic [AW-1:0] r_mem_addr;

    logic          w_sd_rise, w_ready_rise, w_load, w_active, w_adv;
    logic          w_wait_done, w_field_last, w_last_byte;
    logic          w_fetch_go;
    logic [8:0]    w_fetch_idx;
    logic          w_raw_bit, w_wh_mask, w_crc_msb, w_wh_bit;
    logic          w_shift, w_crc_in;

    assign w_sd_rise    = r_sd_sync & ~r_sd_hist;
    assign w_ready_rise = ready & ~r_ready_d;
    assign w_load       = (r_state == S_IDLE) && w_ready_rise;
    assign w_active     = (r_state == S_PRE) || (r_state == S_AA) ||
                          (r_state == S_PDU) || (r_state == S_CRC);
    assign w_adv        = w_sd_rise && w_active;
    assign w_wait_done  = (r_wait_cnt == WW'(MEM_WAIT - 1));
    assign w_last_byte  = (r_byte_cnt == r_pkt_size - 8'd1);
    assign w_raw_bit    = r_byte_buf[r_bit_cnt];
    assign w_wh_mask    = r_whiten_en & w_wh_bit;
    assign w_shift      = w_adv && ((r_state == S_PDU) || (r_state == S_CRC));
    assign w_crc_in     = (r_state == S_PDU) ? w_raw_bit : w_crc_msb;
    assign mem_addr     = r_mem_addr;

    // NOTE: sym_done comes from the divided-clock domain; two flops settle any
    // metastability before the edge detector uses it.
    always_ff @(posedge pll_clko or negedge ble_rst) begin
        if (!ble_rst) begin
            r_sd_meta <= 1'b0;
            r_sd_sync <= 1'b0;
            r_sd_hist <= 1'b0;
            r_ready_d <= 1'b0;
        end else begin
            r_sd_meta <= sym_done;
            r_sd_sync <= r_sd_meta;
            r_sd_hist <= r_sd_sync;
            r_ready_d <= ready;
        end
    end

    always_ff @(posedge pll_clko or negedge ble_rst) begin
        if (!ble_rst) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // NOTE: every combinational output gets a default first so no latch forms.
    always_comb begin
        w_field_last = 1'b0;
        case (r_state)
            S_PRE:   w_field_last = (r_field_cnt == 5'(PRE_LEN - 1));
            S_AA:    w_field_last = (r_field_cnt == 5'(AA_LEN - 1));
            S_CRC:   w_field_last = (r_field_cnt == 5'(CRC_LEN - 1));
            default: w_field_last = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (w_ready_rise) w_state_nxt = S_PREFETCH;
            S_PREFETCH: if (w_wait_done) w_state_nxt = S_PRE;
            S_PRE:      if (w_adv && w_field_last) w_state_nxt = S_AA;
            S_AA: begin
                if (w_adv && w_field_last) begin
                    w_state_nxt = (r_pkt_size == 8'd0) ? S_CRC : S_PDU;
                end
            end
            S_PDU:      if (w_adv && (r_bit_cnt == 3'd7) && w_last_byte) w_state_nxt = S_CRC;
            S_CRC:      if (w_adv && w_field_last) w_state_nxt = S_DONE;
            S_DONE:     if (!ready) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Byte k+1 is requested as soon as bit 0 of byte k goes on air.
    always_comb begin
        w_fetch_go  = 1'b0;
        w_fetch_idx = 9'd0;
        if (w_adv && (r_state == S_AA) && w_field_last && (r_pkt_size > 8'd1)) begin
            w_fetch_go  = 1'b1;
            w_fetch_idx = 9'd1;
        end else if (w_adv && (r_state == S_PDU) && (r_bit_cnt == 3'd7) && !w_last_byte &&
                     (({1'b0, r_byte_cnt} + 9'd2) < {1'b0, r_pkt_size})) begin
            w_fetch_go  = 1'b1;
            w_fetch_idx = {1'b0, r_byte_cnt} + 9'd2;
        end
    end

    always_ff @(posedge pll_clko or negedge ble_rst) begin
        if (!ble_rst) begin
            r_pkt_size   <= '0;
            r_whiten_en  <= 1'b0;
            r_mem_addr   <= '0;
            r_byte_buf   <= '0;
            r_shadow     <= '0;
            r_byte_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_field_cnt  <= '0;
            r_wait_cnt   <= '0;
            r_fetch_busy <= 1'b0;
        end else begin
            if (w_load) begin
                r_pkt_size   <= pkt_size;
                r_whiten_en  <= whiten_en;
                r_mem_addr   <= '0;
                r_byte_cnt   <= '0;
                r_bit_cnt    <= '0;
                r_field_cnt  <= '0;
                r_wait_cnt   <= '0;
                r_fetch_busy <= 1'b0;
            end
            if (r_state == S_PREFETCH) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
                if (w_wait_done) r_byte_buf <= mem_q;
            end
            if (r_fetch_busy) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
                if (w_wait_done) begin
                    r_shadow     <= mem_q;
                    r_fetch_busy <= 1'b0;
                end
            end
            if (w_fetch_go) begin
                r_mem_addr   <= AW'(w_fetch_idx);
                r_wait_cnt   <= '0;
                r_fetch_busy <= 1'b1;
            end
            if (w_adv) begin
                case (r_state)
                    S_PRE, S_AA, S_CRC: begin
                        r_field_cnt <= w_field_last ? 5'd0 : r_field_cnt + 5'd1;
                        r_bit_cnt   <= 3'd0;
                        r_byte_cnt  <= 8'd0;
                    end
                    S_PDU: begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if ((r_bit_cnt == 3'd7) && !w_last_byte) begin
                            r_byte_cnt <= r_byte_cnt + 8'd1;
                            r_byte_buf <= r_shadow;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    ble_crc_whiten #(
        .CRC_INIT (CRC_INIT)
    ) u_crc_whiten (
        .pll_clko  (pll_clko),
        .ble_rst   (ble_rst),
        .load      (w_load),
        .seed      ({1'b1, chan_idx}),
        .shift_crc (w_shift),
        .shift_wh  (w_shift),
        .bit_in    (w_crc_in),
        .crc_msb   (w_crc_msb),
        .wh_bit    (w_wh_bit)
    );

    // Outputs decode straight from the state so start and the first
    // preamble bit appear on the same cycle.
    always_comb begin
        start   = w_active;
        busy    = w_active;
        done    = (r_state == S_DONE);
        sym_val = 1'b0;
        case (r_state)
            S_PRE:   sym_val = PREAMBLE[r_field_cnt[2:0]];
            S_AA:    sym_val = ACCESS_ADDR[r_field_cnt];
            S_PDU:   sym_val = w_raw_bit ^ w_wh_mask;
            S_CRC:   sym_val = w_crc_msb ^ w_wh_mask;
            default: sym_val = 1'b0;
        endcase
    end

endmodule

// File: doc/ble_pkt_framer.md
Name: ble_pkt_framer

Overview:
- Builds the on-air BLE bitstream in front of FSKModulator. It takes over the bit-sourcing role that feeds the modulator's start/symVal/symDone interface.
- Sends, in order: preamble, access address, PDU bytes fetched from ble_packet_mem, then CRC24. Whitening is applied to PDU and CRC.
- Runs on pll_clko. The modulator's symbol-done strobe comes from the divided-clock domain, so it is synchronised inside this block.

Parameters:
- ACCESS_ADDR, 32'h8E89BED6, access address, sent LSB first.
- CRC_INIT, 24'h555555, CRC24 preset.
- MEM_WAIT, 8, pll_clko cycles from mem_addr change to sampling mem_q.
- AW, 8, packet memory address width.

Ports:
- pll_clko  in  1  clock (64 MHz).
- ble_rst  in  1  reset, asynchronous, active-low.
- ready  in  1  packet loaded in memory; level, rising-edge armed.
- pkt_size  in  8  PDU length in bytes, sampled at start.
- chan_idx  in  6  channel index used as whitening seed.
- whiten_en  in  1  1 = whiten PDU+CRC, sampled at start.
- mem_addr  out  AW  packet memory read address.
- mem_q  in  8  packet memory read data.
- sym_done  in  1  modulator symbol-complete, asynchronous to pll_clko.
- start  out  1  modulator enable, high for the whole packet.
- sym_val  out  1  current symbol bit.
- busy  out  1  packet in progress.
- done  out  1  packet finished; held until ready goes low.

Behaviour:
- Reset values: start=0, sym_val=0, busy=0, done=0, mem_addr=0.
  - All state returns to IDLE immediately on reset, including mid-packet.
- sym_done handling:
  - Two-flop synchroniser, then a rising-edge detect. Synchroniser and history flops reset to 0.
  - One edge equals one symbol advance, however long sym_done stays high.
  - Edges are ignored in IDLE, FETCH-only waits and DONE.
- Arming: the ready rising edge is detected on pll_clko, and only in IDLE.
  - ready held high after done does not restart the packet.
  - ready low in DONE clears done and returns to IDLE.
- States:
  - IDLE: on ready rise, latch pkt_size, whiten_en and the seed {1'b1, chan_idx}. Load CRC=CRC_INIT, set mem_addr=0, go to PREFETCH.
  - PREFETCH: wait MEM_WAIT cycles, latch mem_q into the byte buffer. Set start=1 and busy=1, go to PRE.
  - PRE: 8 symbols. The preamble is 8'hAA if ACCESS_ADDR[0]==0, else 8'h55, sent LSB first.
  - AA: 32 symbols, ACCESS_ADDR LSB first.
  - PDU: pkt_size*8 symbols, each byte LSB first.
    - The CRC is updated with the raw (unwhitened) bit.
    - sym_val = raw ^ (whiten_en & lfsr_out).
    - When bit 0 of a byte is presented, mem_addr increments and the next byte is prefetched (MEM_WAIT cycles) into a shadow buffer. The prefetch finishes well inside one symbol.
  - CRC: 24 symbols, CRC register MSB first, whitened if whiten_en.
  - DONE: start=0, busy=0, done=1.
- Symbol timing:
  - sym_val for symbol n+1 is valid within 2 pll_clko cycles after the synchronised sym_done edge of symbol n.
  - The first preamble bit is valid on the cycle start rises.
  - sym_val stays stable otherwise.
- CRC24: polynomial x^24+x^10+x^9+x^6+x^4+x^3+x+1 (0x00065B), LFSR, shifted per PDU bit.
- Whitening: 7-bit LFSR x^7+x^4+1, seeded {1, chan_idx}, advanced once per PDU/CRC symbol.
- Boundary cases:
  - pkt_size=0: PDU is skipped; CRC sends CRC_INIT. No memory read beyond address 0.
  - pkt_size=255: mem_addr ends at 254 and never wraps.
- Counters: a bit counter of 3 bits, a byte counter of 8 bits, and a field counter of 5 bits (up to 32).

Decomposition:
- Package ble_framer_pkg holds:
  - state encoding (IDLE, PREFETCH, PRE, AA, PDU, CRC, DONE);
  - CRC polynomial constant;
  - whitening tap positions;
  - field lengths (8/32/24).
- Sub-module ble_crc_whiten: bit-serial CRC24 plus whitening LFSR.
  - Inputs: load, seed, shift_crc, shift_wh, bit_in.
  - Outputs: crc_msb, wh_bit.

Test Plan:
- Zero-length packet: pkt_size=0, whiten_en=0, one sym_done pulse per 16 pll_clko cycles. Required: 64 symbols = 0,1,0,1,0,1,0,1, then 0x8E89BED6 LSB first (0,1,1,0,1,0,1,1,...), then 24 bits 0,1,0,1,... of 0x555555. done=1 after the last edge.
- Two-byte PDU: mem[0]=8'h02, mem[1]=8'h00, whiten_en=0. Required: PDU bits 0,1,0,0,0,0,0,0 then 8 zeros. CRC equals the golden-model CRC24 of {02,00}. mem_addr goes 0 then 1.
- Whitening: same PDU with chan_idx=37, whiten_en=1. Required: the XOR of the whitened and unwhitened streams over PDU+CRC equals the golden x^7+x^4+1 sequence seeded 7'b1100101. Preamble and AA are unchanged.
- sym_done held high for 40 cycles: required advance of exactly one symbol. A sym_done edge in IDLE does not move state.
- Reset mid-packet: assert ble_rst low during PDU byte 1. Required: start, busy, done and sym_val are all 0 immediately, and mem_addr=0. A new ready rise replays from the preamble.
- Re-arm: ready held high after done gives no second packet. Dropping ready then raising it again sends the packet again, identical bit for bit.
